mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Sequencer for the MEM stage of the pipelined RISC-V core. It turns a load/store sitting in the EX/MEM register into a request/ready transaction on a multi-cycle data memory. While the access is outstanding it freezes the upstream pipeline and injects bubbles into MEM/WB. On completion it presents the loaded word for MEM/WB capture, and on timeout it squashes the access and flags a bus error.

## Interface
Parameters:
- TIMEOUT, 16, max BUSY cycles waiting for memReady before abort (>= 2)
- CNT_W, $clog2(TIMEOUT), width of the wait counter

Ports:
- clk  input  1  core clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- memRead  input  1  EX/MEM: instruction is a load
- memWrite  input  1  EX/MEM: instruction is a store
- ALUResult  input  32  EX/MEM: effective address
- writeData  input  32  EX/MEM: store data
- memReq  output  1  request to data memory (registered)
- memWe  output  1  1 = write, 0 = read (registered)
- memAddr  output  32  address held for the whole request (registered)
- memWData  output  32  write data held for the whole request (registered)
- memReady  input  1  memory completion strobe
- memRData  input  32  read data, valid when memReady=1
- stall  output  1  freeze PC, IF/ID, ID/EX, EX/MEM (combinational)
- bubbleWB  output  1  MEM/WB captures a NOP (regWrite=0) this cycle (combinational)
- memDataOut  output  32  loaded word, fed to MEM/WB memData (registered)
- busError  output  1  sticky timeout flag (registered)
- errAddr  output  32  address of first timed-out access (registered)

## Operation
- States: IDLE, BUSY, DONE, ERR.
- IDLE: access = memRead | memWrite. If access: latch ALUResult -> memAddr, writeData -> memWData, memWe <= memWrite & ~memRead, memReq <= 1, cnt <= 0, go to BUSY. Otherwise stay.
- memRead and memWrite both high: performed as a read (memWe=0). No error raised.
- BUSY: memReq, memAddr, memWData and memWe are held constant.
  - memReady=1: memReq <= 0; if read, memDataOut <= memRData (store leaves memDataOut unchanged); go to DONE.
  - memReady=0 and cnt == TIMEOUT-1: memReq <= 0; busError <= 1; errAddr <= memAddr only if busError was 0; go to ERR.
  - Else cnt <= cnt+1.
- DONE: pipeline advances; MEM/WB captures the completed instruction with memDataOut. Unconditionally return to IDLE. The instruction now in EX/MEM is evaluated the following cycle, so there is no retrigger on the same instruction.
- ERR: pipeline advances with bubbleWB=1, so the faulting instruction is squashed. Return to IDLE.
- stall = (IDLE & access) | BUSY.
- bubbleWB = stall | ERR.
- memReady is ignored outside BUSY.
- busError is cleared only by rst.

## Timing
- Reset (async, immediate): state=IDLE, memReq=0, memWe=0, memAddr=0, memWData=0, memDataOut=0, busError=0, errAddr=0, cnt=0. A reset during BUSY drops memReq immediately and abandons the access.
- Minimum access (ready on first BUSY cycle) takes 3 cycles: T0 IDLE (stall=1), T1 BUSY (stall=1, memReq=1), T2 DONE (stall=0, bubbleWB=0). Upstream is frozen 2 cycles; MEM/WB gets 2 bubbles.
- Ready on BUSY cycle k (1 <= k <= TIMEOUT) gives 2+k cycles, with stall high for 1+k cycles.
- Timeout occurs after exactly TIMEOUT BUSY cycles with no ready. memReady=1 on the TIMEOUT-th BUSY cycle completes normally: ready wins over timeout.
- Back-to-back memory instructions: DONE -> IDLE -> new access, giving exactly one non-stalled cycle (DONE) between them.
- Non-memory instructions add zero latency: stall=0 and bubbleWB=0 in IDLE.

## Test plan
- **Reset:** assert rst mid-BUSY -> memReq=0 in the same cycle, all outputs 0, state IDLE; deassert, then a non-memory instruction passes with stall=0.
- **Load, 1-cycle ready:** memRead=1, ALUResult=0x100, memReady=1 with memRData=0xCAFEF00D on first BUSY cycle -> memAddr=0x100, memWe=0, stall high 2 cycles, memDataOut=0xCAFEF00D in DONE, bubbleWB low in DONE.
- **Store, 5-cycle wait:** memWrite=1, addr 0x20, writeData 0x12345678, ready on 5th BUSY cycle -> memWe=1, memWData held 5 cycles, stall high 6 cycles, memDataOut unchanged.
- **Timeout:** TIMEOUT=16, memRead with memReady never asserted -> memReq drops after 16 BUSY cycles, ERR with bubbleWB=1 and stall=0, busError=1, errAddr=access address. A second timeout leaves errAddr unchanged.
- **Ready at boundary:** ready on the 16th BUSY cycle -> DONE, busError stays 0.
- **Corner inputs:** memRead=memWrite=1 -> read performed (memWe=0). Spurious memReady in IDLE -> no state change. Two consecutive loads -> exactly one DONE cycle between the two stall windows.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: runs one request/ready transaction per memory
// instruction, freezes upstream while it is outstanding, and aborts on timeout.
module mem_access_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] writeData,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memReady,
    input  logic [31:0] memRData,
    output logic        stall,
    output logic        bubbleWB,
    output logic [31:0] memDataOut,
    output logic        busError,
    output logic [31:0] errAddr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      dout_q, dout_d;
    logic             berr_q, berr_d;
    logic [31:0]      eaddr_q, eaddr_d;

    logic access;
    assign access = memRead | memWrite;

    always_comb begin
        // NOTE: every next-state signal starts as a copy of its register, so no
        // path through the case can leave one unassigned and infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        dout_d  = dout_q;
        berr_d  = berr_q;
        eaddr_d = eaddr_q;

        case (state_q)
            S_IDLE: begin
                if (access) begin
                    addr_d  = ALUResult;
                    wdata_d = writeData;
                    we_d    = memWrite & ~memRead;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Ready is tested first so a reply on the last allowed cycle completes.
                if (memReady) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        dout_d = memRData;
                    end
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d  = 1'b0;
                    berr_d = 1'b1;
                    if (!berr_q) begin
                        eaddr_d = addr_q;
                    end
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            dout_q  <= '0;
            berr_q  <= 1'b0;
            eaddr_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            dout_q  <= dout_d;
            berr_q  <= berr_d;
            eaddr_q <= eaddr_d;
        end
    end

    assign memReq     = req_q;
    assign memWe      = we_q;
    assign memAddr    = addr_q;
    assign memWData   = wdata_q;
    assign memDataOut = dout_q;
    assign busError   = berr_q;
    assign errAddr    = eaddr_q;

    assign stall    = ((state_q == S_IDLE) & access) | (state_q == S_BUSY);
    assign bubbleWB = stall | (state_q == S_ERR);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the driver queues the expected outcome
// of each access, the monitor checks it when the request drops.
module tb_mem_access_ctrl;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memRead = 1'b0, memWrite = 1'b0;
    logic [31:0] ALUResult = '0, writeData = '0;
    logic        memReq, memWe;
    logic [31:0] memAddr, memWData;
    logic        memReady = 1'b0;
    logic [31:0] memRData = '0;
    logic        stall, bubbleWB;
    logic [31:0] memDataOut;
    logic        busError;
    logic [31:0] errAddr;

    mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .memRead(memRead), .memWrite(memWrite),
        .ALUResult(ALUResult), .writeData(writeData),
        .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
        .memReady(memReady), .memRData(memRData),
        .stall(stall), .bubbleWB(bubbleWB),
        .memDataOut(memDataOut), .busError(busError), .errAddr(errAddr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        is_err;
        logic [31:0] dout;
        logic        bus_err;
        logic [31:0] err_addr;
        int          stall_len;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] m_dout  = '0;
    logic        m_berr  = 1'b0;
    logic [31:0] m_eaddr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ready_k = BUSY cycle on which memReady is asserted; 0 means never (timeout).
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input int ready_k,
                             input logic [31:0] rdata);
        exp_t e;
        int   n;
        n = (ready_k == 0) ? TIMEOUT : ready_k;
        e.addr      = addr;
        e.wdata     = wdata;
        e.we        = wr & ~rd;
        e.is_err    = (ready_k == 0);
        e.stall_len = 1 + n;
        if (!e.is_err && !e.we) m_dout = rdata;
        if (e.is_err) begin
            if (!m_berr) m_eaddr = addr;
            m_berr = 1'b1;
        end
        e.dout     = m_dout;
        e.bus_err  = m_berr;
        e.err_addr = m_eaddr;
        sb.push_back(e);

        memRead   = rd;
        memWrite  = wr;
        ALUResult = addr;
        writeData = wdata;
        #1;
        check("idle_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        for (int i = 1; i <= n; i++) begin
            memReady = (i == ready_k);
            memRData = (i == ready_k) ? rdata : (32'hDEAD0000 | i);
            @(posedge clk); #1;
        end
        memReady = 1'b0;
        @(posedge clk); #1;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    // Monitor: tracks stall runs, request stability, and scores each completion.
    initial begin
        logic        prev_req = 1'b0;
        int          run = 0;
        int          held_bad = 0;
        logic [31:0] cap_addr = '0, cap_wdata = '0;
        logic        cap_we = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                run = 0;
            end else begin
                if (memReq && !prev_req) begin
                    cap_addr = memAddr; cap_wdata = memWData; cap_we = memWe;
                    held_bad = 0;
                end else if (memReq) begin
                    if (memAddr !== cap_addr || memWData !== cap_wdata || memWe !== cap_we)
                        held_bad++;
                end
                if (!memReq && prev_req) begin
                    if (sb.size() == 0) begin
                        check("sb_unexpected_completion", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("req_addr", cap_addr, e.addr);
                        check("req_wdata", cap_wdata, e.wdata);
                        check("req_we", {31'd0, cap_we}, {31'd0, e.we});
                        check("req_held", held_bad, 0);
                        check("stall_len", run, e.stall_len);
                        check("end_stall", {31'd0, stall}, 32'd0);
                        check("end_bubble", {31'd0, bubbleWB}, {31'd0, e.is_err});
                        check("mem_data_out", memDataOut, e.dout);
                        check("bus_error", {31'd0, busError}, {31'd0, e.bus_err});
                        check("err_addr", errAddr, e.err_addr);
                    end
                end
                if (stall) run++;
                else run = 0;
                prev_req = memReq;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        check("rst_req", {31'd0, memReq}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_dout", memDataOut, 32'd0);
        check("rst_berr", {31'd0, busError}, 32'd0);
        #9 rst = 1'b0;
        @(posedge clk); #1;

        // Non-memory instruction adds no latency.
        #3;
        check("nonmem_stall", {31'd0, stall}, 32'd0);
        check("nonmem_bubble", {31'd0, bubbleWB}, 32'd0);
        @(posedge clk); #1;

        do_access(1'b1, 1'b0, 32'h0000_0100, 32'h0, 1, 32'hCAFE_F00D);
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 5, 32'h0);

        // Spurious ready while idle must not start or complete anything.
        memReady = 1'b1;
        memRData = 32'hFFFF_0000;
        repeat (2) @(posedge clk);
        #1;
        check("spur_req", {31'd0, memReq}, 32'd0);
        check("spur_stall", {31'd0, stall}, 32'd0);
        check("spur_dout", memDataOut, m_dout);
        memReady = 1'b0;
        @(posedge clk); #1;

        do_access(1'b1, 1'b1, 32'h0000_0044, 32'h7777_7777, 2, 32'h5A5A_1234);
        do_access(1'b1, 1'b0, 32'h0000_0300, 32'h0, TIMEOUT, 32'h0BAD_BEEF);

        // Back-to-back loads: second stall window starts right after DONE.
        do_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 3, 32'h1111_2222);
        do_access(1'b1, 1'b0, 32'h0000_0404, 32'h0, 1, 32'h3333_4444);

        do_access(1'b1, 1'b0, 32'h0000_0500, 32'h0, 0, 32'h0);
        do_access(1'b0, 1'b1, 32'h0000_0600, 32'hABCD_0000, 0, 32'h0);
        do_access(1'b1, 1'b0, 32'h0000_0700, 32'h0, 1, 32'h5555_6666);

        // Reset in the middle of BUSY abandons the access at once.
        memRead   = 1'b1;
        ALUResult = 32'h0000_0800;
        @(posedge clk); #1;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_req", {31'd0, memReq}, 32'd1);
        #1;
        rst     = 1'b1;
        memRead = 1'b0;
        #1;
        check("mid_rst_req", {31'd0, memReq}, 32'd0);
        check("mid_rst_addr", memAddr, 32'd0);
        check("mid_rst_stall", {31'd0, stall}, 32'd0);
        check("mid_rst_bubble", {31'd0, bubbleWB}, 32'd0);
        check("mid_rst_dout", memDataOut, 32'd0);
        check("mid_rst_berr", {31'd0, busError}, 32'd0);
        check("mid_rst_eaddr", errAddr, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_dout = '0; m_berr = 1'b0; m_eaddr = '0;
        #3;
        check("post_rst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;

        do_access(1'b1, 1'b0, 32'h0000_0900, 32'h0, 2, 32'h9999_0000);
        repeat (2) @(posedge clk);
        #1;
        check("sb_drain", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
